// File: rtl/mux_8_pkg.sv
// Shared constants and types for the registered 8-to-1 data selector.
package mux_8_pkg;

    localparam int NUM_IN = 8;
    localparam int SEL_W  = 3;

    typedef logic [SEL_W-1:0] sel_t;

endpackage : mux_8_pkg

// File: rtl/mux_8.sv
// Registered 8-to-1 data selector with valid qualifier and output hold.
// The select is a pure combinational case; dout, sel_q and out_valid are
// flop outputs, so there is no glitch path from sel to dout.
module mux_8
    import mux_8_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    input  logic [WIDTH-1:0] in5,
    input  logic [WIDTH-1:0] in6,
    input  logic [WIDTH-1:0] in7,
    input  logic [SEL_W-1:0] sel,
    input  logic             in_valid,
    input  logic             hold,
    output logic [WIDTH-1:0] dout,
    output logic             out_valid,
    output logic [SEL_W-1:0] sel_q
);

    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] dout_d;
    logic [WIDTH-1:0] dout_q;
    sel_t             sel_d;
    logic             valid_d;
    logic             valid_q;

    // Pick in[sel]; all eight codes are legal so no error branch exists.
    always_comb begin
        // NOTE: assigning a default before the case keeps this block purely
        // combinational even if a branch is later edited away (no latch).
        sel_data = '0;
        case (sel)
            3'd0: sel_data = in0;
            3'd1: sel_data = in1;
            3'd2: sel_data = in2;
            3'd3: sel_data = in3;
            3'd4: sel_data = in4;
            3'd5: sel_data = in5;
            3'd6: sel_data = in6;
            3'd7: sel_data = in7;
        endcase
    end

    // Next-state: hold freezes everything; a bubble only clears out_valid.
    always_comb begin
        dout_d  = dout_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        if (!hold) begin
            valid_d = in_valid;
            if (in_valid) begin
                dout_d = sel_data;
                sel_d  = sel;
            end
        end
    end

    // Output stage with synchronous active-low reset that overrides hold.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every flop samples the
        // pre-edge values regardless of statement order.
        if (!rst_n) begin
            dout_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
        end
    end

    assign dout      = dout_q;
    assign out_valid = valid_q;

endmodule : mux_8

// File: tb/tb_mux_8.sv
// Self-checking bench for mux_8: directed scenarios followed by random
// stimulus, compared against a behavioural reference model. A second
// instance with WIDTH = 16 shares the control inputs.
module tb_mux_8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  sel;
    logic        in_valid;
    logic        hold;
    logic [7:0]  d8  [8];
    logic [15:0] d16 [8];

    logic [7:0]  dout8;
    logic        out_valid8;
    logic [2:0]  sel_q8;
    logic [15:0] dout16;
    logic        out_valid16;
    logic [2:0]  sel_q16;

    // Reference model state
    logic [7:0]  exp_dout8;
    logic [15:0] exp_dout16;
    logic        exp_valid;
    logic [2:0]  exp_sel;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mux_8 #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in0(d8[0]), .in1(d8[1]), .in2(d8[2]), .in3(d8[3]),
        .in4(d8[4]), .in5(d8[5]), .in6(d8[6]), .in7(d8[7]),
        .sel(sel), .in_valid(in_valid), .hold(hold),
        .dout(dout8), .out_valid(out_valid8), .sel_q(sel_q8)
    );

    mux_8 #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in0(d16[0]), .in1(d16[1]), .in2(d16[2]), .in3(d16[3]),
        .in4(d16[4]), .in5(d16[5]), .in6(d16[6]), .in7(d16[7]),
        .sel(sel), .in_valid(in_valid), .hold(hold),
        .dout(dout16), .out_valid(out_valid16), .sel_q(sel_q16)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one edge, update the model from the rules, then compare.
    task automatic tick(input string tag);
        @(posedge clk);
        if (!rst_n) begin
            exp_dout8  = '0;
            exp_dout16 = '0;
            exp_valid  = 1'b0;
            exp_sel    = '0;
        end else if (!hold) begin
            exp_valid = in_valid;
            if (in_valid) begin
                exp_dout8  = d8[sel];
                exp_dout16 = d16[sel];
                exp_sel    = sel;
            end
        end
        #1;
        check({tag, ".dout8"},   16'(dout8),       16'(exp_dout8));
        check({tag, ".valid8"},  16'(out_valid8),  16'(exp_valid));
        check({tag, ".sel8"},    16'(sel_q8),      16'(exp_sel));
        check({tag, ".dout16"},  dout16,           exp_dout16);
        check({tag, ".valid16"}, 16'(out_valid16), 16'(exp_valid));
        check({tag, ".sel16"},   16'(sel_q16),     16'(exp_sel));
    endtask

    initial begin
        exp_dout8  = '0;
        exp_dout16 = '0;
        exp_valid  = 1'b0;
        exp_sel    = '0;
        for (int n = 0; n < 8; n++) begin
            d8[n]  = 8'h10 + 8'(n);
            d16[n] = 16'h1000 + 16'(n);
        end

        // Reset with a valid sample present: outputs stay zero.
        rst_n    = 1'b0;
        in_valid = 1'b1;
        hold     = 1'b0;
        sel      = 3'd5;
        d8[5]    = 8'hA5;
        #2;
        tick("reset0");
        tick("reset1");
        check("reset_dout_const", 16'(dout8), 16'h0000);

        // Sweep all select codes.
        rst_n = 1'b1;
        d8[5] = 8'h15;
        for (int n = 0; n < 8; n++) begin
            sel = 3'(n);
            tick("sweep");
            check("sweep_const", 16'(dout8), 16'h0010 + 16'(n));
        end

        // Reset pulse mid-stream, then sel = 2 is the first accepted sample.
        sel = 3'd4;
        rst_n = 1'b0;
        tick("midrst");
        rst_n = 1'b1;
        sel = 3'd2;
        tick("after_rst");
        check("after_rst_const", 16'(dout8), 16'h0012);

        // Hold freezes outputs and drops samples.
        sel   = 3'd3;
        d8[3] = 8'h3C;
        tick("hold_load");
        hold  = 1'b1;
        sel   = 3'd6;
        for (int n = 0; n < 3; n++) begin
            tick("hold");
            check("hold_const", 16'(dout8), 16'h003C);
        end
        hold = 1'b0;
        tick("hold_rel");
        check("hold_rel_const", 16'(dout8), 16'h0016);

        // Bubble: out_valid drops, dout keeps its value.
        d8[1] = 8'h55;
        sel   = 3'd1;
        tick("bubble_load");
        in_valid = 1'b0;
        sel      = 3'd7;
        tick("bubble");
        check("bubble_const", 16'(dout8), 16'h0055);

        // Wide instance boundary value.
        in_valid = 1'b1;
        d16[7]   = 16'hBEEF;
        sel      = 3'd7;
        tick("width");
        check("width_const", dout16, 16'hBEEF);

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            for (int n = 0; n < 8; n++) begin
                d8[n]  = 8'($urandom);
                d16[n] = 16'($urandom);
            end
            sel      = 3'($urandom_range(0, 7));
            in_valid = ($urandom_range(0, 3) != 0);
            hold     = ($urandom_range(0, 3) == 0);
            rst_n    = ($urandom_range(0, 31) != 0);
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mux_8
